// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RISC-V core.
// Owns the program counter and drives the word address to a zero-latency
// instruction memory. Captures the returned word into the IF/ID register.
// Applies hazard stalls, EX flushes and redirects. Stops fetching permanently
// (until reset) when a redirect target is not word aligned.
//
// Control semantics (one place, so checkers can bind against it):
//   - Pipeline control is level-based and sampled on every rising clk_i edge.
//   - In RUN, exactly one action is taken per edge, in this priority order:
//       redirect_i > flush_i > stall_i > advance.
//   - redirect_i (aligned target): load the target into the PC and insert a
//     bubble. The redirect wins over any stall in the same cycle, because the
//     instruction being fetched is wrong-path anyway.
//   - redirect_i (misaligned target): keep the PC, insert a bubble, pulse
//     misalign_o for one cycle, latch the target and enter HALT.
//   - flush_i: insert a bubble. The PC still advances unless stall_i is also
//     high, in which case the PC holds.
//   - stall_i alone: the PC and the entire IF/ID register hold.
//   - advance: the PC steps by 4 and IF/ID captures {pc, pc+4, im_data_i}.
//   - A bubble clears valid_o and drives NOP_INSTR. pc_o and pc_plus4_o hold.
//   - In HALT, every input is ignored and IF/ID is a bubble on every edge.
//   - halted_o exposes the fetch FSM state directly.

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o
);

  // Fetch FSM encoding
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Architectural state
  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // IF/ID pipeline register
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;

  // Misalignment reporting and fetch statistics
  logic        misalign_q;
  logic [31:0] misalign_addr_q;
  logic [31:0] fetch_cnt_q;

  // Decoded per-edge actions (mutually exclusive)
  logic        in_run;
  logic        target_misaligned;
  logic        act_redirect;
  logic        act_halt;
  logic        act_flush;
  logic        act_stall;
  logic        act_advance;
  logic        insert_bubble;
  logic [31:0] pc_inc;

  assign pc_inc            = pc_q + 32'd4;
  assign in_run            = (state_q == ST_RUN);
  assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);

  // Decode the single action taken this edge using the fixed priority order
  always_comb begin
    act_redirect  = 1'b0;
    act_halt      = 1'b0;
    act_flush     = 1'b0;
    act_stall     = 1'b0;
    act_advance   = 1'b0;
    if (in_run) begin
      if (redirect_i) begin
        if (target_misaligned) begin
          act_halt = 1'b1;
        end else begin
          act_redirect = 1'b1;
        end
      end else if (flush_i) begin
        act_flush = 1'b1;
      end else if (stall_i) begin
        act_stall = 1'b1;
      end else begin
        act_advance = 1'b1;
      end
    end
  end

  // In HALT the IF/ID register is forced to a bubble every cycle
  assign insert_bubble = !in_run || act_redirect || act_halt || act_flush;

  // Next PC: redirect loads the target, flush advances unless stalled too
  always_comb begin
    pc_d = pc_q;
    if (act_redirect) begin
      pc_d = redirect_pc_i;
    end else if (act_flush) begin
      pc_d = stall_i ? pc_q : pc_inc;
    end else if (act_advance) begin
      pc_d = pc_inc;
    end
  end

  // Next FSM state: only a misaligned redirect leaves RUN; HALT is sticky
  always_comb begin
    state_d = state_q;
    if (act_halt) begin
      state_d = ST_HALT;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Program counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID register: bubble, capture on advance, otherwise hold (stall)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (insert_bubble) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (act_advance) begin
      ifid_pc_q    <= pc_q;
      ifid_pc4_q   <= pc_inc;
      ifid_instr_q <= im_data_i;
      ifid_valid_q <= 1'b1;
    end
  end

  // Misalign pulse lasts one cycle; the offending target is held until replaced
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0000_0000;
    end else begin
      misalign_q <= act_halt;
      if (act_halt) begin
        misalign_addr_q <= redirect_pc_i;
      end
    end
  end

  // Count real captures into IF/ID; wraps modulo 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'h0000_0000;
    end else if (act_advance) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  // The instruction memory is word indexed
  assign im_addr_o       = {2'b00, pc_q[31:2]};
  assign pc_o            = ifid_pc_q;
  assign pc_plus4_o      = ifid_pc4_q;
  assign instr_o         = ifid_instr_q;
  assign valid_o         = ifid_valid_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
  assign halted_o        = (state_q == ST_HALT);
  assign fetch_cnt_o     = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a small combinational instruction
// memory model and hand-computed expected values.

module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] im_addr_o;
  logic [31:0] im_data_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
  logic        halted_o;
  logic [31:0] fetch_cnt_o;

  // Instruction memory model: 64 words, zero latency
  logic [31:0] mem [64];
  assign im_data_i = mem[im_addr_o[5:0]];

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .im_addr_o       (im_addr_o),
    .im_data_i       (im_data_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o),
    .halted_o        (halted_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = tgt;
  endtask

  // Check the full IF/ID register contents plus the fetch address and count
  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                            input logic [31:0] e_instr, input logic e_valid,
                            input logic [31:0] e_addr, input logic [31:0] e_cnt);
    check({tag, ".pc"},    pc_o,              e_pc);
    check({tag, ".pc4"},   pc_plus4_o,        e_pc4);
    check({tag, ".instr"}, instr_o,           e_instr);
    check({tag, ".valid"}, {31'd0, valid_o},  {31'd0, e_valid});
    check({tag, ".addr"},  im_addr_o,         e_addr);
    check({tag, ".cnt"},   fetch_cnt_o,       e_cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_1000 + i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_ifid("rst", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    check("rst.mis",   {31'd0, misalign_o}, 32'h0);
    check("rst.maddr", misalign_addr_o,     32'h0);
    check("rst.halt",  {31'd0, halted_o},   32'h0);
    rst = 1'b0;

    // Straight-line fetch
    tick(); check_ifid("seq0", 32'h0, 32'h4, 32'h11, 1'b1, 32'd1, 32'd1);
    tick(); check_ifid("seq1", 32'h4, 32'h8, 32'h22, 1'b1, 32'd2, 32'd2);
    tick(); check_ifid("seq2", 32'h8, 32'hC, 32'h33, 1'b1, 32'd3, 32'd3);

    // Two-cycle stall holds everything
    set_ctl(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); check_ifid("stall0", 32'h8, 32'hC, 32'h33, 1'b1, 32'd3, 32'd3);
    tick(); check_ifid("stall1", 32'h8, 32'hC, 32'h33, 1'b1, 32'd3, 32'd3);
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); check_ifid("unstall", 32'hC, 32'h10, 32'h44, 1'b1, 32'd4, 32'd4);

    // Redirect wins over a simultaneous stall
    set_ctl(1'b1, 1'b0, 1'b1, 32'h40);
    tick(); check_ifid("redir", 32'hC, 32'h10, NOP, 1'b0, 32'd16, 32'd4);
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); check_ifid("redir.cap", 32'h40, 32'h44, 32'h0000_1010, 1'b1, 32'd17, 32'd5);

    // Move to pc=8, then flush alone advances, flush with stall holds
    set_ctl(1'b0, 1'b0, 1'b1, 32'h8);
    tick(); check_ifid("to8", 32'h40, 32'h44, NOP, 1'b0, 32'd2, 32'd5);
    set_ctl(1'b0, 1'b1, 1'b0, 32'h0);
    tick(); check_ifid("flush", 32'h40, 32'h44, NOP, 1'b0, 32'd3, 32'd5);
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    tick(); check_ifid("flush.stall", 32'h40, 32'h44, NOP, 1'b0, 32'd3, 32'd5);
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); check_ifid("post.flush", 32'hC, 32'h10, 32'h44, 1'b1, 32'd4, 32'd6);

    // PC wrap at the top of the address space
    set_ctl(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(); check_ifid("wrap.redir", 32'hC, 32'h10, NOP, 1'b0, 32'h3FFF_FFFF, 32'd6);
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); check_ifid("wrap.cap", 32'hFFFF_FFFC, 32'h0, 32'h0000_103F, 1'b1, 32'd0, 32'd7);
    tick(); check_ifid("wrap.next", 32'h0, 32'h4, 32'h11, 1'b1, 32'd1, 32'd8);

    // Misaligned redirect halts fetch at pc=4
    set_ctl(1'b0, 1'b0, 1'b1, 32'h42);
    tick();
    check_ifid("mis", 32'h0, 32'h4, NOP, 1'b0, 32'd1, 32'd8);
    check("mis.pulse", {31'd0, misalign_o}, 32'h1);
    check("mis.addr",  misalign_addr_o,     32'h42);
    check("mis.halt",  {31'd0, halted_o},   32'h1);

    // HALT ignores every input for 10 cycles
    for (int i = 0; i < 10; i++) begin
      set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 255) << 2);
      tick();
      check_ifid("halt", 32'h0, 32'h4, NOP, 1'b0, 32'd1, 32'd8);
      check("halt.pulse", {31'd0, misalign_o}, 32'h0);
      check("halt.addr",  misalign_addr_o,     32'h42);
      check("halt.flag",  {31'd0, halted_o},   32'h1);
    end

    // Asynchronous reset in the middle of HALT acts immediately
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_ifid("arst", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    check("arst.halt",  {31'd0, halted_o}, 32'h0);
    check("arst.maddr", misalign_addr_o,   32'h0);
    tick();
    rst = 1'b0;
    tick(); check_ifid("arst.run", 32'h0, 32'h4, 32'h11, 1'b1, 32'd1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V core. It owns the program counter and drives the word address into the instruction memory, which returns the word combinationally in the same cycle. It captures the returned instruction into the IF/ID pipeline register. It also applies stalls from the hazard unit and redirects/flushes from EX, and halts fetch on a misaligned redirect target.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
NOP_INSTR, 32'h0000_0013, encoding driven on instr_o for bubbles (addi x0,x0,0)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
stall_i  input  1  hazard unit: hold PC and IF/ID contents
flush_i  input  1  EX: kill IF/ID contents (insert bubble)
redirect_i  input  1  EX: taken branch/jump, load redirect_pc_i
redirect_pc_i  input  32  byte target address
im_addr_o  output  32  word index to instruction memory, {2'b00, pc[31:2]}
im_data_i  input  32  instruction word from memory, same cycle
pc_o  output  32  IF/ID: PC of held instruction
pc_plus4_o  output  32  IF/ID: pc_o + 4
instr_o  output  32  IF/ID: instruction (NOP_INSTR when invalid)
valid_o  output  1  IF/ID: instruction is real
misalign_o  output  1  registered one-cycle pulse: misaligned redirect seen
misalign_addr_o  output  32  offending target, held until next misalign or reset
halted_o  output  1  fetch FSM is in HALT
fetch_cnt_o  output  32  count of instructions captured into IF/ID

Behaviour:
- Reset (async, any cycle, including mid-stall or in HALT): pc=RESET_PC, FSM=RUN, pc_o=0, pc_plus4_o=0, instr_o=NOP_INSTR, valid_o=0, misalign_o=0, misalign_addr_o=0, halted_o=0, fetch_cnt_o=0.
- im_addr_o is purely combinational from the pc register. There is zero-cycle memory latency: the IF/ID register captures im_data_i on the same edge at which the PC advances.
- FSM states RUN and HALT. RUN->HALT on redirect_i=1 with redirect_pc_i[1:0]!=0. HALT->RUN only by reset.
- RUN priority per edge is redirect > flush > stall > advance:
  - Redirect, aligned: pc<=redirect_pc_i; IF/ID<=bubble; ignores stall_i. The wrong-path fetch is discarded.
  - Redirect, misaligned: pc unchanged; IF/ID<=bubble; misalign_o<=1 for one cycle; misalign_addr_o<=redirect_pc_i; FSM<=HALT.
  - flush_i, no redirect: IF/ID<=bubble. pc<=pc+4 unless stall_i=1, in which case pc holds.
  - stall_i only: pc and the whole IF/ID register hold, including valid_o.
  - Otherwise: pc<=pc+4; pc_o<=pc; pc_plus4_o<=pc+4; instr_o<=im_data_i; valid_o<=1; fetch_cnt_o+=1.
- Bubble means valid_o=0 and instr_o=NOP_INSTR; pc_o and pc_plus4_o hold their previous values.
- HALT: pc frozen; IF/ID forced to bubble every cycle; all inputs ignored; halted_o=1.
- PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC advances to 0. fetch_cnt_o wraps from 32'hFFFF_FFFF to 0.
- fetch_cnt_o increments only on an advance edge with a real capture. It never increments on stall, flush, redirect or HALT.

Test Plan:
- Reset, then mem[0..3]=11,22,33,44 with no stall -> im_addr_o 0,1,2,3 on consecutive cycles. IF/ID shows (pc_o,instr_o) = (0,11), (4,22), (8,33). valid_o=1 from the first edge. fetch_cnt_o=3 after three edges.
- stall_i=1 for 2 cycles while IF/ID holds (8,33) -> im_addr_o stays 3; IF/ID stays (8,33); fetch_cnt_o unchanged. Releasing the stall gives (12,44) on the next edge.
- redirect_i=1, redirect_pc_i=32'h40, stall_i=1 in the same cycle -> next cycle im_addr_o=16, valid_o=0, instr_o=32'h13. The following edge captures (0x40, mem[16]).
- flush_i=1 alone at pc=8 -> IF/ID bubble, im_addr_o advances to 3. flush_i=1 together with stall_i=1 -> bubble, im_addr_o holds.
- redirect_pc_i=32'h42 -> misalign_o pulses one cycle, misalign_addr_o=32'h42, halted_o=1, valid_o=0 thereafter for 10 cycles regardless of inputs. Asserting rst_i mid-HALT gives halted_o=0 and im_addr_o=0 immediately.
- Force pc near wrap by redirecting to 32'hFFFF_FFFC -> the next advance gives im_addr_o=0, and pc_plus4_o of that capture is 0.
